// File: rtl/altufm_osc.sv
// altufm_osc: divides clk into a 50%-duty oscillator gated by oscena, never emitting runt pulses.
// Optional macro ALTUFM_OSC_SYNC_EN inserts a 2-flop synchronizer on oscena.
module altufm_osc #(
   parameter int HALF_PERIOD = 1,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic oscena,
   output logic osc,
   output logic osc_active
);

   localparam int HP = (HALF_PERIOD < 1) ? 1 : HALF_PERIOD;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HP - 1);

   logic             en_int;
   logic             running;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             osc_q, osc_d;
   logic             act_q, act_d;

`ifdef ALTUFM_OSC_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= oscena;
         sync2_q <= sync1_q;
      end
   end

   assign en_int = sync2_q;
`else
   assign en_int = oscena;
`endif

   // A started low phase (count in progress, or low phase after a fall with enable
   // still high) keeps counting even if enable drops; the rise decision is made only
   // at the edge where the phase completes.
   always_comb begin
      cnt_d   = cnt_q;
      osc_d   = osc_q;
      act_d   = act_q;
      running = en_int | osc_q | act_q | (cnt_q != '0);
      if (running) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (osc_q) begin
               osc_d = 1'b0;
               if (!en_int) begin
                  act_d = 1'b0;
               end
            end else if (en_int) begin
               osc_d = 1'b1;
               act_d = 1'b1;
            end else begin
               act_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         osc_q <= 1'b0;
         act_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         osc_q <= osc_d;
         act_q <= act_d;
      end
   end

   assign osc        = osc_q;
   assign osc_active = act_q;

endmodule

// File: tb/tb_altufm_osc.sv
// Self-checking bench for altufm_osc: five instances (HALF_PERIOD 1,3,4,5,2) against a phase-age model.
module tb_altufm_osc;

   localparam int N = 5;
`ifdef ALTUFM_OSC_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   logic         clk = 1'b0;
   logic [N-1:0] rst_v = '1;
   logic [N-1:0] en_v  = '0;
   logic [N-1:0] osc_v;
   logic [N-1:0] act_v;

   always #5 clk = ~clk;

   altufm_osc #(.HALF_PERIOD(1), .CNT_W(8)) u_hp1 (.clk(clk), .rst(rst_v[0]), .oscena(en_v[0]), .osc(osc_v[0]), .osc_active(act_v[0]));
   altufm_osc #(.HALF_PERIOD(3), .CNT_W(8)) u_hp3 (.clk(clk), .rst(rst_v[1]), .oscena(en_v[1]), .osc(osc_v[1]), .osc_active(act_v[1]));
   altufm_osc #(.HALF_PERIOD(4), .CNT_W(8)) u_hp4 (.clk(clk), .rst(rst_v[2]), .oscena(en_v[2]), .osc(osc_v[2]), .osc_active(act_v[2]));
   altufm_osc #(.HALF_PERIOD(5), .CNT_W(3)) u_hp5 (.clk(clk), .rst(rst_v[3]), .oscena(en_v[3]), .osc(osc_v[3]), .osc_active(act_v[3]));
   altufm_osc #(.HALF_PERIOD(2), .CNT_W(2)) u_hp2 (.clk(clk), .rst(rst_v[4]), .oscena(en_v[4]), .osc(osc_v[4]), .osc_active(act_v[4]));

   int checks = 0;
   int passed = 0;

   // model state: age = edges elapsed in the current phase, busy = a low phase is in progress
   int m_age  [N];
   bit m_osc  [N];
   bit m_act  [N];
   bit m_busy [N];
   bit m_s1   [N];
   bit m_s2   [N];

   function automatic int hp_of(input int i);
      case (i)
         0:       return 1;
         1:       return 3;
         2:       return 4;
         3:       return 5;
         default: return 2;
      endcase
   endfunction

   task automatic model_edge();
      for (int i = 0; i < N; i++) begin
         if (rst_v[i]) begin
            m_age[i] = 0; m_osc[i] = 0; m_act[i] = 0; m_busy[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
         end else begin
            bit e;
            e = (SL != 0) ? m_s2[i] : en_v[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = en_v[i];
            if (m_busy[i] || m_osc[i] || e) begin
               m_age[i]++;
               if (m_age[i] == hp_of(i)) begin
                  m_age[i] = 0;
                  if (m_osc[i]) begin
                     m_osc[i] = 0;
                     if (!e) begin m_busy[i] = 0; m_act[i] = 0; end
                  end else if (e) begin
                     m_osc[i] = 1; m_act[i] = 1; m_busy[i] = 1;
                  end else begin
                     m_busy[i] = 0; m_act[i] = 0;
                  end
               end else begin
                  m_busy[i] = 1;
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      en_v  = '0;
      rst_v = '1;
      tick();
      rst_v = '0;
   endtask

   task automatic test_reset();
      en_v  = N'($urandom);
      rst_v = '1;
      repeat (3) tick();
      for (int i = 0; i < N; i++) begin
         checks++;
         if (osc_v[i] !== 1'b0 || act_v[i] !== 1'b0)
            $display("FAIL reset[%0d] got osc=%b act=%b need 0/0", i, osc_v[i], act_v[i]);
         else passed++;
      end
      en_v  = '0;
      rst_v = '0;
   endtask

   task automatic test_continuous();
      int first0 = -1, first4 = -1, rises1 = 0;
      logic prev1 = 1'b0;
      en_v = '1;
      for (int e = 1; e <= 60; e++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            checks++;
            if (osc_v[i] !== m_osc[i] || act_v[i] !== m_act[i])
               $display("FAIL cont[%0d] edge %0d got osc=%b act=%b need %b/%b", i, e, osc_v[i], act_v[i], m_osc[i], m_act[i]);
            else passed++;
         end
         if (first0 < 0 && osc_v[0] === 1'b1) first0 = e;
         if (first4 < 0 && osc_v[4] === 1'b1) first4 = e;
         if (osc_v[1] === 1'b1 && prev1 === 1'b0) rises1++;
         prev1 = osc_v[1];
      end
      checks++;
      if (first0 != 1 + SL) $display("FAIL first_rise_hp1 got %0d need %0d", first0, 1 + SL); else passed++;
      checks++;
      if (first4 != 2 + SL) $display("FAIL first_rise_hp2 got %0d need %0d", first4, 2 + SL); else passed++;
      checks++;
      if (rises1 != 10) $display("FAIL rises_hp3_60cyc got %0d need 10", rises1); else passed++;
   endtask

   task automatic test_drop();
      int hi = 0, k = 0;
      do_reset();
      en_v[2] = 1'b1;
      while (osc_v[2] !== 1'b1 && k < 40) begin tick(); k++; end
      checks++;
      if (osc_v[2] !== 1'b1) $display("FAIL drop_rise_timeout got %b need 1", osc_v[2]); else passed++;
      hi = 1;
      tick();
      en_v[2] = 1'b0;
      for (int e = 0; e < 20; e++) begin
         if (osc_v[2] === 1'b1) hi++;
         checks++;
         if (osc_v[2] !== m_osc[2] || act_v[2] !== osc_v[2])
            $display("FAIL drop edge %0d got osc=%b act=%b need osc=%b act=osc", e, osc_v[2], act_v[2], m_osc[2]);
         else passed++;
         tick();
      end
      checks++;
      if (hi != 4) $display("FAIL drop_high_len got %0d need 4", hi); else passed++;
      checks++;
      if (osc_v[2] !== 1'b0 || act_v[2] !== 1'b0) $display("FAIL drop_final got %b/%b need 0/0", osc_v[2], act_v[2]); else passed++;
   endtask

   task automatic test_async_reset();
      int k = 0, first = -1;
      do_reset();
      en_v[3] = 1'b1;
      while (osc_v[3] !== 1'b1 && k < 40) begin tick(); k++; end
      checks++;
      if (osc_v[3] !== 1'b1) $display("FAIL arst_rise_timeout got %b need 1", osc_v[3]); else passed++;
      tick();
      tick();
      #2 rst_v[3] = 1'b1;
      #1;
      checks++;
      if (osc_v[3] !== 1'b0) $display("FAIL arst_osc_immediate got %b need 0", osc_v[3]); else passed++;
      checks++;
      if (act_v[3] !== 1'b0) $display("FAIL arst_act_immediate got %b need 0", act_v[3]); else passed++;
      tick();
      rst_v[3] = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (first < 0 && osc_v[3] === 1'b1) first = e;
         checks++;
         if (osc_v[3] !== m_osc[3] || act_v[3] !== m_act[3])
            $display("FAIL arst_restart edge %0d got %b/%b need %b/%b", e, osc_v[3], act_v[3], m_osc[3], m_act[3]);
         else passed++;
      end
      checks++;
      if (first != 5 + SL) $display("FAIL arst_first_rise got %0d need %0d", first, 5 + SL); else passed++;
   endtask

   task automatic test_low_toggle();
      int run = 0, since_fall = -1;
      bit seen_rise = 0;
      logic prev = 1'b0;
      do_reset();
      en_v[1] = 1'b1;
      for (int e = 0; e < 40; e++) begin
         tick();
         checks++;
         if (osc_v[1] !== m_osc[1] || act_v[1] !== m_act[1])
            $display("FAIL lowtog edge %0d got %b/%b need %b/%b", e, osc_v[1], act_v[1], m_osc[1], m_act[1]);
         else passed++;
         if (osc_v[1] !== prev) begin
            if (seen_rise) begin
               checks++;
               if (run != 3) $display("FAIL lowtog_phase_len got %0d need 3", run); else passed++;
            end
            if (osc_v[1] === 1'b1) seen_rise = 1;
            if (osc_v[1] === 1'b0 && since_fall < 0) since_fall = 0;
            run = 1;
         end else begin
            run++;
         end
         prev = osc_v[1];
         if (since_fall >= 0) begin
            if (since_fall == 1) en_v[1] = 1'b0;
            if (since_fall == 2) en_v[1] = 1'b1;
            since_fall++;
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int e = 0; e < 400; e++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(7) == 0) en_v[i] = ~en_v[i];
            rst_v[i] = ($urandom_range(63) == 0);
         end
         tick();
         for (int i = 0; i < N; i++) begin
            checks++;
            if (osc_v[i] !== m_osc[i] || act_v[i] !== m_act[i])
               $display("FAIL rand[%0d] edge %0d got %b/%b need %b/%b", i, e, osc_v[i], act_v[i], m_osc[i], m_act[i]);
            else passed++;
         end
      end
      rst_v = '0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         m_age[i] = 0; m_osc[i] = 0; m_act[i] = 0; m_busy[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
      end
      @(negedge clk);
      test_reset();
      test_continuous();
      test_drop();
      test_async_reset();
      test_low_toggle();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
